// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types, widths and torus index helper for the Game of Life board
package gol_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } gol_state_t;

  localparam int NBR_W = 4;

  // Row-major index of (row, col) with both coordinates folded onto the torus.
  function automatic int wrap_idx(input int row, input int col, input int n);
    int r;
    int c;
    r = ((row % n) + n) % n;
    c = ((col % n) + n) % n;
    return r * n + c;
  endfunction

endpackage

// File: rtl/gol_board_if.sv
// rtl/gol_board_if.sv - load/step controls and board status between a controller and gol_board
interface gol_board_if #(
  parameter int N     = 8,
  parameter int GEN_W = 16
);

  logic             load_start;
  logic             load_valid;
  logic             load_bit;
  logic             step;
  logic [N*N-1:0]   cells;
  logic             busy;
  logic [GEN_W-1:0] generation;
  logic             stable;
  logic             extinct;

  modport master (
    output load_start, load_valid, load_bit, step,
    input  cells, busy, generation, stable, extinct
  );

  modport slave (
    input  load_start, load_valid, load_bit, step,
    output cells, busy, generation, stable, extinct
  );

endinterface

// File: rtl/gol_cell_next.sv
// rtl/gol_cell_next.sv - B3/S23 next-state for one cell from its 8 neighbours
module gol_cell_next
  import gol_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       cur,
  output logic       nxt
);

  function automatic logic [3:0] adder3(input logic [2:0] a, input logic [2:0] b, input logic cin);
    logic [3:0] s;
    logic       c;
    c = cin;
    for (int k = 0; k < 3; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    s[3] = c;
    return s;
  endfunction

  logic [3:0]       sum_lo_full;
  logic [3:0]       sum_hi_full;
  logic [2:0]       sum_lo;
  logic [2:0]       sum_hi;
  logic [NBR_W-1:0] count;
  logic             unused_carry;

  // Each group of four neighbours: a half-adder pair, the third bit as an operand, the fourth as carry-in.
  assign sum_lo_full = adder3({1'b0, nbr[0] & nbr[1], nbr[0] ^ nbr[1]}, {2'b00, nbr[2]}, nbr[3]);
  assign sum_hi_full = adder3({1'b0, nbr[4] & nbr[5], nbr[4] ^ nbr[5]}, {2'b00, nbr[6]}, nbr[7]);
  assign sum_lo      = sum_lo_full[2:0];
  assign sum_hi      = sum_hi_full[2:0];
  assign unused_carry = sum_lo_full[3] | sum_hi_full[3];

  assign count = adder3(sum_lo, sum_hi, 1'b0);
  assign nxt   = (count == NBR_W'(3)) || (cur && (count == NBR_W'(2)));

endmodule

// File: rtl/gol_board.sv
// rtl/gol_board.sv - toroidal Game of Life board: serial pattern load, one generation per step
module gol_board
  import gol_pkg::*;
#(
  parameter int N     = 8,
  parameter int GEN_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  gol_board_if.slave bus
);

  localparam int             CELLS = N * N;
  localparam int             CNT_W = $clog2(CELLS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CELLS - 1);

  gol_state_t       state;
  logic [CNT_W-1:0] load_cnt;
  logic [CELLS-1:0] cells_q;
  logic [CELLS-1:0] next_cells;
  logic [GEN_W-1:0] gen_q;
  logic             stable_q;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [7:0] nbr;

      assign nbr = {cells_q[wrap_idx(r - 1, c - 1, N)],
                    cells_q[wrap_idx(r - 1, c,     N)],
                    cells_q[wrap_idx(r - 1, c + 1, N)],
                    cells_q[wrap_idx(r,     c - 1, N)],
                    cells_q[wrap_idx(r,     c + 1, N)],
                    cells_q[wrap_idx(r + 1, c - 1, N)],
                    cells_q[wrap_idx(r + 1, c,     N)],
                    cells_q[wrap_idx(r + 1, c + 1, N)]};

      gol_cell_next u_cell (
        .nbr (nbr),
        .cur (cells_q[r * N + c]),
        .nxt (next_cells[r * N + c])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      cells_q  <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Load outranks step when both arrive together.
          if (bus.load_start) begin
            state    <= S_LOAD;
            load_cnt <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
          end else if (bus.step) begin
            cells_q  <= next_cells;
            gen_q    <= gen_q + GEN_W'(1);
            stable_q <= (next_cells == cells_q);
          end
        end
        S_LOAD: begin
          // Bits enter at the top and shift down, so bit k ends in cells[k] after the last one.
          if (bus.load_valid) begin
            cells_q <= {bus.load_bit, cells_q[CELLS-1:1]};
            if (load_cnt == LAST_BIT) begin
              state    <= S_IDLE;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cells      = cells_q;
  assign bus.busy       = (state == S_LOAD);
  assign bus.generation = gen_q;
  assign bus.stable     = stable_q;
  assign bus.extinct    = ~|cells_q;

endmodule

// File: tb/tb_gol_board.sv
// tb/tb_gol_board.sv - self-checking bench for gol_board on 5x5, 4x4 (2-bit counter) and 8x8 boards
module tb_gol_board;

  logic clk;
  logic rst_n;

  logic ls [3];
  logic lv [3];
  logic lb [3];
  logic st [3];

  logic [63:0] cel [3];
  logic [15:0] gen [3];
  logic        bsy [3];
  logic        stb [3];
  logic        ext [3];

  int n_chk  = 0;
  int n_fail = 0;
  int nbits [3] = '{25, 16, 64};

  gol_board_if #(.N(5), .GEN_W(16)) if5 ();
  gol_board_if #(.N(4), .GEN_W(2))  if4 ();
  gol_board_if #(.N(8), .GEN_W(16)) if8 ();

  gol_board #(.N(5), .GEN_W(16)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  gol_board #(.N(4), .GEN_W(2))  dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  gol_board #(.N(8), .GEN_W(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  assign if5.load_start = ls[0];
  assign if5.load_valid = lv[0];
  assign if5.load_bit   = lb[0];
  assign if5.step       = st[0];
  assign if4.load_start = ls[1];
  assign if4.load_valid = lv[1];
  assign if4.load_bit   = lb[1];
  assign if4.step       = st[1];
  assign if8.load_start = ls[2];
  assign if8.load_valid = lv[2];
  assign if8.load_bit   = lb[2];
  assign if8.step       = st[2];

  assign cel[0] = 64'(if5.cells);
  assign cel[1] = 64'(if4.cells);
  assign cel[2] = if8.cells;
  assign gen[0] = if5.generation;
  assign gen[1] = 16'(if4.generation);
  assign gen[2] = if8.generation;
  assign bsy[0] = if5.busy;
  assign bsy[1] = if4.busy;
  assign bsy[2] = if8.busy;
  assign stb[0] = if5.stable;
  assign stb[1] = if4.stable;
  assign stb[2] = if8.stable;
  assign ext[0] = if5.extinct;
  assign ext[1] = if4.extinct;
  assign ext[2] = if8.extinct;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          d;
    logic [63:0] pat;
    int          steps;
    logic [63:0] exp_cells;
    logic [15:0] exp_gen;
    logic        exp_stable;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input logic [63:0] pat);
    ls[d] = 1'b1;
    cyc();
    ls[d] = 1'b0;
    for (int i = 0; i < nbits[d]; i++) begin
      lv[d] = 1'b1;
      lb[d] = pat[i];
      cyc();
    end
    lv[d] = 1'b0;
    lb[d] = 1'b0;
  endtask

  task automatic do_step(input int d);
    st[d] = 1'b1;
    cyc();
    st[d] = 1'b0;
  endtask

  // Reference: count the 8 torus neighbours of every cell and apply B3/S23.
  function automatic logic [63:0] model_next(input logic [63:0] b, input int n);
    logic [63:0] r;
    int cnt;
    r = '0;
    for (int row = 0; row < n; row++) begin
      for (int col = 0; col < n; col++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(b[((row + dr + n) % n) * n + ((col + dc + n) % n)]);
        r[row * n + col] = (cnt == 3) || (cnt == 2 && b[row * n + col]);
      end
    end
    return r;
  endfunction

  initial begin
    logic [63:0] model;
    logic [63:0] nxt;
    logic [63:0] pat;
    int          busy_cnt;

    vecs[0] = '{0, 64'h3800, 0, 64'h3800,  16'd0, 1'b0};
    vecs[1] = '{0, 64'h3800, 1, 64'h21080, 16'd1, 1'b0};
    vecs[2] = '{0, 64'h3800, 2, 64'h3800,  16'd2, 1'b0};
    vecs[3] = '{1, 64'h9009, 1, 64'h9009,  16'd1, 1'b1};
    vecs[4] = '{1, 64'h0033, 3, 64'h0033,  16'd3, 1'b1};
    vecs[5] = '{1, 64'h0001, 1, 64'h0000,  16'd1, 1'b0};
    vecs[6] = '{1, 64'h0001, 2, 64'h0000,  16'd2, 1'b1};
    vecs[7] = '{1, 64'h0001, 5, 64'h0000,  16'd1, 1'b1};
    vecs[8] = '{1, 64'h0000, 1, 64'h0000,  16'd1, 1'b1};
    vecs[9] = '{1, 64'h0070, 1, 64'h0222,  16'd1, 1'b0};

    for (int d = 0; d < 3; d++) begin
      ls[d] = 1'b0;
      lv[d] = 1'b0;
      lb[d] = 1'b0;
      st[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      cyc();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("reset_cells d%0d", d), cel[d], 64'h0);
        chk($sformatf("reset_gen d%0d", d), 64'(gen[d]), 64'h0);
        chk($sformatf("reset_busy d%0d", d), 64'(bsy[d]), 64'h0);
        chk($sformatf("reset_stable d%0d", d), 64'(stb[d]), 64'h0);
        chk($sformatf("reset_extinct d%0d", d), 64'(ext[d]), 64'h1);
      end
    end

    for (int v = 0; v < 10; v++) begin
      load(vecs[v].d, vecs[v].pat);
      for (int s = 0; s < vecs[v].steps; s++) do_step(vecs[v].d);
      chk($sformatf("vec%0d cells", v), cel[vecs[v].d], vecs[v].exp_cells);
      chk($sformatf("vec%0d gen", v), 64'(gen[vecs[v].d]), 64'(vecs[v].exp_gen));
      chk($sformatf("vec%0d stable", v), 64'(stb[vecs[v].d]), 64'(vecs[v].exp_stable));
      chk($sformatf("vec%0d extinct", v), 64'(ext[vecs[v].d]), 64'(vecs[v].exp_cells == 64'h0));
      chk($sformatf("vec%0d busy", v), 64'(bsy[vecs[v].d]), 64'h0);
    end

    // Stalled load with step and load_start pulses on every idle slot.
    do_step(1);
    pat = 64'hA5C3;
    ls[1] = 1'b1;
    cyc();
    ls[1] = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bsy[1]) busy_cnt++;
      lv[1] = 1'b0;
      st[1] = 1'b1;
      ls[1] = 1'b1;
      cyc();
      st[1] = 1'b0;
      ls[1] = 1'b0;
      if (bsy[1]) busy_cnt++;
      lv[1] = 1'b1;
      lb[1] = pat[i];
      cyc();
      lv[1] = 1'b0;
    end
    chk("stall busy_cycles", 64'(busy_cnt), 64'd32);
    chk("stall busy_after", 64'(bsy[1]), 64'h0);
    chk("stall cells", cel[1], pat);
    chk("stall gen", 64'(gen[1]), 64'h0);

    // load_start and step in the same idle cycle.
    load(1, 64'h0001);
    do_step(1);
    load(1, 64'h0001);
    ls[1] = 1'b1;
    st[1] = 1'b1;
    cyc();
    ls[1] = 1'b0;
    st[1] = 1'b0;
    chk("prio busy", 64'(bsy[1]), 64'h1);
    chk("prio cells", cel[1], 64'h0001);
    chk("prio gen", 64'(gen[1]), 64'h0);
    pat = 64'h0033;
    for (int i = 0; i < 16; i++) begin
      lv[1] = 1'b1;
      lb[1] = pat[i];
      cyc();
    end
    lv[1] = 1'b0;
    chk("prio reload cells", cel[1], 64'h0033);
    chk("prio reload busy", 64'(bsy[1]), 64'h0);

    // Asynchronous reset after 7 of 16 bits.
    ls[1] = 1'b1;
    cyc();
    ls[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      lv[1] = 1'b1;
      lb[1] = 1'b1;
      cyc();
    end
    chk("midload partial cells", cel[1], 64'hFE00);
    chk("midload partial busy", 64'(bsy[1]), 64'h1);
    #3;
    rst_n = 1'b0;
    lv[1] = 1'b0;
    lb[1] = 1'b0;
    #1;
    chk("midload rst cells", cel[1], 64'h0);
    chk("midload rst busy", 64'(bsy[1]), 64'h0);
    chk("midload rst gen", 64'(gen[1]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("midload idle busy", 64'(bsy[1]), 64'h0);
    load(1, 64'h8421);
    chk("midload reload cells", cel[1], 64'h8421);
    chk("midload reload busy", 64'(bsy[1]), 64'h0);

    // Random 8x8 boards against the reference model.
    for (int r = 0; r < 8; r++) begin
      model = {32'($urandom), 32'($urandom)};
      if (r == 0) model = 64'h0000_0000_0000_0000;
      load(2, model);
      chk($sformatf("rand%0d load", r), cel[2], model);
      for (int s = 0; s < 4; s++) begin
        do_step(2);
        nxt = model_next(model, 8);
        chk($sformatf("rand%0d step%0d cells", r, s), cel[2], nxt);
        chk($sformatf("rand%0d step%0d stable", r, s), 64'(stb[2]), 64'(nxt == model));
        chk($sformatf("rand%0d step%0d gen", r, s), 64'(gen[2]), 64'(s + 1));
        chk($sformatf("rand%0d step%0d extinct", r, s), 64'(ext[2]), 64'(nxt == 64'h0));
        model = nxt;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_board.md
Name: gol_board

Overview:
- NxN toroidal Conway's Game of Life board; the sequential stage that consumes the neighbour sums produced by the team's 3-bit ripple adders.
- Holds all cell state in registers.
- Loads an initial pattern serially.
- Advances one generation per accepted step pulse (B3/S23 rule, full-parallel update).
- Reports generation count and stable/extinct status to the top level (display/LED driver).

Parameters:
N, 8, board edge length; board holds N*N cells (N >= 3)
GEN_W, 16, generation counter width

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse: begin serial pattern load
load_valid  input  1  load_bit is valid this cycle (honoured only in S_LOAD)
load_bit  input  1  serial pattern bit, row-major, cell 0 first
step  input  1  one-cycle pulse: compute next generation
cells  output  N*N  current board; index = row*N + col
busy  output  1  high while in S_LOAD
generation  output  GEN_W  generations stepped since last load
stable  output  1  last accepted step produced no change
extinct  output  1  all cells zero (combinational from cells)

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - cells = 0, generation = 0, busy = 0, stable = 0
  - extinct = 1 (follows cells)
  - FSM = S_IDLE, load counter = 0
- FSM states: S_IDLE, S_LOAD.
- S_IDLE + load_start=1:
  - next cycle enters S_LOAD; busy = 1.
  - load counter, generation and stable all clear to 0.
  - cells are unchanged.
- S_LOAD:
  - each cycle with load_valid=1 shifts load_bit into cells[N*N-1]; cells shift right by one.
  - after exactly N*N valid bits, bit k of the sequence sits in cells[k].
  - on the edge accepting the N*N-th bit: return to S_IDLE, busy = 0 the following cycle.
  - load_valid=0 cycles stall, with no timeout.
- S_IDLE + step=1 (and load_start=0):
  - on the same edge, cells <= next_cells.
  - generation <= generation + 1, wrapping modulo 2^GEN_W.
  - stable <= (next_cells == cells).
  - latency is 1 cycle: the new board is visible the cycle after step.
- next_cells[i], combinational:
  - count = number of live cells among the 8 neighbours, range 0..8, 4 bits wide.
  - neighbour coordinates wrap modulo N in both row and column (torus).
  - live cell survives iff count is 2 or 3.
  - dead cell is born iff count is 3.
- Priority and boundary rules:
  - load_start and step in the same S_IDLE cycle: load wins, step is dropped.
  - step, or a repeated load_start, during S_LOAD: ignored, no effect.
  - step while extinct: accepted; generation increments, stable -> 1.
  - rst_n asserted mid-load: immediate abort; all reset values apply; the partial pattern is discarded.
- Steps are not queued; a level-held step advances once per cycle.

Decomposition:
- Shared package gol_pkg:
  - typedef enum logic {S_IDLE, S_LOAD} gol_state_t
  - localparam NBR_W = 4 (neighbour count width)
  - function wrap_idx(row, col, N) returning row*N + col with modulo-N wrap
- Sub-module gol_cell_next:
  - inputs: 8 neighbour bits and the current cell bit; output: the next cell bit.
  - neighbour count built as an adder3 tree: two 3-bit partial sums of 4 bits each, using the carry in for the 8th bit.
  - instantiated N*N times in a generate loop.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, no stimulus -> cells=0, generation=0, busy=0, stable=0, extinct=1 for 10 cycles.
- Blinker, N=5:
  - load bits 11, 12, 13 set -> cells=0x3800, busy low after the 25th bit.
  - step -> cells=0x21080, generation=1, stable=0.
  - step -> cells=0x3800, generation=2.
- Toroidal wrap, N=4:
  - load corners 0, 3, 12, 15 (cells=0x9009).
  - step -> cells stay 0x9009, stable=1, generation=1.
  - with wrap broken, all corners would die; this catches that bug.
- Load stall and priority, N=4:
  - load 16 bits with load_valid toggled every other cycle -> busy holds for about 32 cycles and the pattern is correct.
  - step pulses during the load -> generation stays 0.
  - load_start+step together in S_IDLE -> enters S_LOAD, generation unchanged.
- Reset mid-load: assert rst_n=0 asynchronously (between clock edges) after 7 of 16 bits -> cells=0, busy=0 immediately, FSM S_IDLE; a subsequent full load succeeds.
- Extinction and counter wrap:
  - single live cell, then step -> cells=0, extinct=1, stable=0.
  - step again -> stable=1.
  - with GEN_W=2, five steps -> generation=1.
